// File: rtl/vis_readout_scheduler_pkg.sv
// Shared types and default sizing for the visibility readout scheduler.
// Defaults match an 18-core correlator with 16 words of 36 bits per core.
package vis_readout_scheduler_pkg;
  localparam int VRS_CORES = 18;
  localparam int VRS_ADDR  = 4;
  localparam int VRS_ACCUM = 36;
  localparam int VRS_FBITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } vrs_state_t;
endpackage

// File: rtl/vis_readout_scheduler_axis_skid2.sv
// Two-entry output FIFO with an occupancy count. The writer must only push
// when space is guaranteed, because in_valid has no ready back-pressure.
module vis_readout_scheduler_axis_skid2
  import vis_readout_scheduler_pkg::*;
#(
  parameter int W = VRS_ACCUM + 1
) (
  input  logic         vis_clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic              pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge vis_clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/vis_readout_scheduler.sv
// Drains the completed visibility bank of every correlator core after a bank
// swap, core-major, into a back-pressured stream; flags swaps that arrive early.
module vis_readout_scheduler
  import vis_readout_scheduler_pkg::*;
#(
  parameter int CORES = VRS_CORES,
  parameter int ADDR  = VRS_ADDR,
  parameter int ACCUM = VRS_ACCUM,
  parameter int CBITS = $clog2(CORES),
  parameter int FBITS = VRS_FBITS
) (
  input  logic             vis_clock,
  input  logic             reset,
  input  logic             swap_i,
  input  logic             bank_i,
  input  logic             clear_i,
  output logic             rd_en_o,
  output logic             rd_bank_o,
  output logic [CBITS-1:0] rd_core_o,
  output logic [ADDR-1:0]  rd_addr_o,
  input  logic [ACCUM-1:0] rd_data_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [ACCUM-1:0] m_tdata_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [FBITS-1:0] frames_o
);
  localparam logic [CBITS-1:0] LAST_CORE = CBITS'(CORES - 1);

  vrs_state_t     state;
  logic           inflight, inflight_last;
  logic [1:0]     fifo_count;
  logic [ACCUM:0] fifo_out;
  logic           pop, last_rd, credit_ok, tlast_hs, overrun_evt;

  assign last_rd   = (rd_core_o == LAST_CORE) && (&rd_addr_o);
  assign pop       = m_tvalid_o && m_tready_i;
  // A read may issue only if its data is guaranteed a FIFO slot when it returns.
  assign credit_ok = ({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign rd_en_o   = (state == ST_READ) && credit_ok;
  assign tlast_hs  = pop && m_tlast_o;
  // A swap landing on the final handshake starts the next frame instead.
  assign overrun_evt = swap_i && busy_o && !tlast_hs;

  vis_readout_scheduler_axis_skid2 #(.W(ACCUM + 1)) u_fifo (
    .vis_clock (vis_clock),
    .reset     (reset),
    .in_valid  (inflight),
    .in_data   ({inflight_last, rd_data_i}),
    .out_valid (m_tvalid_o),
    .out_ready (m_tready_i),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign {m_tlast_o, m_tdata_o} = fifo_out;

  always_ff @(posedge vis_clock or posedge reset) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      inflight      <= rd_en_o;
      inflight_last <= rd_en_o && last_rd;
      overrun_o     <= overrun_evt | (overrun_o & ~clear_i);
    end
  end

  always_ff @(posedge vis_clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy_o    <= 1'b0;
      rd_bank_o <= 1'b0;
      rd_core_o <= '0;
      rd_addr_o <= '0;
      frames_o  <= '0;
    end else begin
      if (tlast_hs) frames_o <= frames_o + 1'b1;
      // Counters stop on the final address so they hold once reads finish.
      if (rd_en_o && !last_rd) begin
        rd_addr_o <= rd_addr_o + 1'b1;
        if (&rd_addr_o) rd_core_o <= rd_core_o + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (swap_i) begin
            state     <= ST_READ;
            busy_o    <= 1'b1;
            rd_bank_o <= bank_i;
            rd_core_o <= '0;
            rd_addr_o <= '0;
          end
        end
        ST_READ: begin
          if (rd_en_o && last_rd) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (tlast_hs) begin
            if (swap_i) begin
              state     <= ST_READ;
              rd_bank_o <= bank_i;
              rd_core_o <= '0;
              rd_addr_o <= '0;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
